cr16_control_fsm: RTL and testbench

Multi-cycle instruction controller that sits directly upstream of the CR16 datapath. It owns the program counter, fetches 16-bit instructions from synchronous memory, decodes them, and drives every datapath control input: register write enable, A/B selects, immediate, ALU opcode and regfile-data select. It replaces the hard-wired test sequencer with real instruction-driven control.

---
 rtl/cr16_pkg.sv | 58 +++++
 rtl/cr16_control_fsm_if.sv | 30 +++
 rtl/cr16_decoder.sv | 53 +++++
 rtl/cr16_control_fsm.sv | 133 +++++++++++++
 tb/tb_cr16_control_fsm.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cr16_pkg.sv
// Shared types and encodings for the CR16 instruction controller:
// FSM states, ALU opcodes, instruction op/opext fields and small decode helpers.
package cr16_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_LOAD_ADDR = 3'd3,
    ST_LOAD_WB   = 3'd4,
    ST_STORE     = 3'd5
  } state_t;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_CMP = 4'd6;
  localparam logic [3:0] ALU_MOV = 4'd8;

  // The same code space is used for IR[15:12] (immediate forms) and IR[7:4] (opext).
  localparam logic [3:0] OP_RR  = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_MEM = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b1101;

  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;

  function automatic logic [3:0] alu_map(input logic [3:0] code);
    case (code)
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_CMP:  return ALU_CMP;
      OP_MOV:  return ALU_MOV;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic logic is_load(input logic [15:0] ir);
    return (ir[15:12] == OP_MEM) && (ir[7:4] == EXT_LOAD);
  endfunction

  function automatic logic is_store(input logic [15:0] ir);
    return (ir[15:12] == OP_MEM) && (ir[7:4] == EXT_STOR);
  endfunction

endpackage

// File: rtl/cr16_control_fsm_if.sv
// Bus between the CR16 controller, its instruction/data memory and the datapath.
// The controller is the master; memory/datapath side is the slave.
interface cr16_control_fsm_if;
  logic [15:0] I_MEM_RDATA;
  logic [15:0] O_PC;
  logic        O_MEM_ADDR_SELECT;
  logic        O_MEM_WRITE_ENABLE;
  logic [15:0] O_REG_WRITE_ENABLE;
  logic [3:0]  O_REG_A_SELECT;
  logic [3:0]  O_REG_B_SELECT;
  logic        O_IMMEDIATE_SELECT;
  logic [15:0] O_IMMEDIATE;
  logic [3:0]  O_OPCODE;
  logic        O_REGFILE_DATA_SELECT;
  logic [2:0]  O_STATE;

  modport master (
    input  I_MEM_RDATA,
    output O_PC, O_MEM_ADDR_SELECT, O_MEM_WRITE_ENABLE, O_REG_WRITE_ENABLE,
           O_REG_A_SELECT, O_REG_B_SELECT, O_IMMEDIATE_SELECT, O_IMMEDIATE,
           O_OPCODE, O_REGFILE_DATA_SELECT, O_STATE
  );

  modport slave (
    output I_MEM_RDATA,
    input  O_PC, O_MEM_ADDR_SELECT, O_MEM_WRITE_ENABLE, O_REG_WRITE_ENABLE,
           O_REG_A_SELECT, O_REG_B_SELECT, O_IMMEDIATE_SELECT, O_IMMEDIATE,
           O_OPCODE, O_REGFILE_DATA_SELECT, O_STATE
  );
endinterface

// File: rtl/cr16_decoder.sv
// Combinational instruction decoder: classifies an IR word and produces the
// ALU opcode, extended immediate and whether the destination register is written.
module cr16_decoder
  import cr16_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [3:0]  o_opcode,
  output logic [15:0] o_imm,
  output logic        o_imm_sel,
  output logic        o_write_en,
  output logic        o_is_load,
  output logic        o_is_store,
  output logic        o_valid
);

  logic [3:0] w_op;
  logic [3:0] w_rr_code;
  logic [3:0] w_imm_code;
  logic       w_imm_signed;

  assign w_op         = i_ir[15:12];
  assign w_rr_code    = alu_map(i_ir[7:4]);
  assign w_imm_code   = alu_map(w_op);
  // Arithmetic immediates are signed; logical and move immediates are not.
  assign w_imm_signed = (w_imm_code == ALU_ADD) || (w_imm_code == ALU_SUB) ||
                        (w_imm_code == ALU_CMP);

  always_comb begin
    o_opcode   = ALU_NOP;
    o_imm      = 16'h0000;
    o_imm_sel  = 1'b0;
    o_write_en = 1'b0;
    o_is_load  = is_load(i_ir);
    o_is_store = is_store(i_ir);
    o_valid    = 1'b0;
    if (w_op == OP_RR) begin
      if (w_rr_code != ALU_NOP) begin
        o_valid    = 1'b1;
        o_opcode   = w_rr_code;
        o_write_en = (w_rr_code != ALU_CMP);
      end
    end else if (w_op == OP_MEM) begin
      o_valid = o_is_load | o_is_store;
    end else if (w_imm_code != ALU_NOP) begin
      o_valid    = 1'b1;
      o_opcode   = w_imm_code;
      o_imm_sel  = 1'b1;
      o_write_en = (w_imm_code != ALU_CMP);
      o_imm      = w_imm_signed ? {{8{i_ir[7]}}, i_ir[7:0]} : {8'h00, i_ir[7:0]};
    end
  end

endmodule

// File: rtl/cr16_control_fsm.sv
// Multi-cycle CR16 instruction controller: owns PC and IR, fetches from
// synchronous memory and drives all datapath control as Moore outputs.
module cr16_control_fsm
  import cr16_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic                      I_CLK,
  input  logic                      I_NRESET,
  input  logic                      I_ENABLE,
  cr16_control_fsm_if.master        bus
);

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;

  logic [3:0]  w_dec_opcode;
  logic [15:0] w_dec_imm;
  logic        w_dec_imm_sel;
  logic        w_dec_write_en;
  logic        w_dec_is_load;
  logic        w_dec_is_store;
  logic        w_dec_valid;
  logic        w_exec_ok;
  logic [3:0]  w_rdest;
  logic [3:0]  w_rsrc;
  logic [15:0] w_rdest_onehot;

  logic        w_mem_addr_sel;
  logic        w_mem_we;
  logic [15:0] w_reg_we;
  logic [3:0]  w_a_sel;
  logic [3:0]  w_b_sel;
  logic        w_imm_sel;
  logic [15:0] w_imm;
  logic [3:0]  w_opcode;
  logic        w_rf_data_sel;

  cr16_decoder u_decoder (
    .i_ir       (r_ir),
    .o_opcode   (w_dec_opcode),
    .o_imm      (w_dec_imm),
    .o_imm_sel  (w_dec_imm_sel),
    .o_write_en (w_dec_write_en),
    .o_is_load  (w_dec_is_load),
    .o_is_store (w_dec_is_store),
    .o_valid    (w_dec_valid)
  );

  assign w_rdest        = r_ir[11:8];
  assign w_rsrc         = r_ir[3:0];
  assign w_rdest_onehot = 16'h0001 << w_rdest;
  assign w_exec_ok      = w_dec_valid & ~w_dec_is_load & ~w_dec_is_store;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_state <= ST_FETCH;
      r_pc    <= PC_RESET;
      r_ir    <= 16'h0000;
    end else if (I_ENABLE) begin
      case (r_state)
        ST_FETCH: r_state <= ST_DECODE;
        ST_DECODE: begin
          // Memory returns the word addressed during FETCH; branch on it directly.
          r_ir <= bus.I_MEM_RDATA;
          r_pc <= r_pc + 16'd1;
          if (is_load(bus.I_MEM_RDATA))       r_state <= ST_LOAD_ADDR;
          else if (is_store(bus.I_MEM_RDATA)) r_state <= ST_STORE;
          else                                r_state <= ST_EXECUTE;
        end
        ST_EXECUTE:   r_state <= ST_FETCH;
        ST_LOAD_ADDR: r_state <= ST_LOAD_WB;
        ST_LOAD_WB:   r_state <= ST_FETCH;
        ST_STORE:     r_state <= ST_FETCH;
        default:      r_state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    w_mem_addr_sel = 1'b0;
    w_mem_we       = 1'b0;
    w_reg_we       = 16'h0000;
    w_a_sel        = 4'h0;
    w_b_sel        = 4'h0;
    w_imm_sel      = 1'b0;
    w_imm          = 16'h0000;
    w_opcode       = ALU_NOP;
    w_rf_data_sel  = 1'b0;
    case (r_state)
      ST_EXECUTE: begin
        // Unrecognised encodings fall through with everything at zero (NOP).
        if (w_exec_ok) begin
          w_a_sel   = w_rdest;
          w_b_sel   = w_rsrc;
          w_opcode  = w_dec_opcode;
          w_imm_sel = w_dec_imm_sel;
          w_imm     = w_dec_imm;
          w_reg_we  = w_dec_write_en ? w_rdest_onehot : 16'h0000;
        end
      end
      ST_LOAD_ADDR: begin
        w_mem_addr_sel = 1'b1;
        w_a_sel        = w_rsrc;
      end
      ST_LOAD_WB: begin
        w_rf_data_sel = 1'b1;
        w_reg_we      = w_rdest_onehot;
      end
      ST_STORE: begin
        w_mem_addr_sel = 1'b1;
        w_mem_we       = 1'b1;
        w_a_sel        = w_rsrc;
        w_b_sel        = w_rdest;
      end
      default: ;
    endcase
  end

  assign bus.O_PC                  = r_pc;
  assign bus.O_MEM_ADDR_SELECT     = w_mem_addr_sel;
  assign bus.O_MEM_WRITE_ENABLE    = w_mem_we;
  assign bus.O_REG_WRITE_ENABLE    = w_reg_we;
  assign bus.O_REG_A_SELECT        = w_a_sel;
  assign bus.O_REG_B_SELECT        = w_b_sel;
  assign bus.O_IMMEDIATE_SELECT    = w_imm_sel;
  assign bus.O_IMMEDIATE           = w_imm;
  assign bus.O_OPCODE              = w_opcode;
  assign bus.O_REGFILE_DATA_SELECT = w_rf_data_sel;
  assign bus.O_STATE               = r_state;

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Bench for cr16_control_fsm: directed plus random programs, each cycle's
// outputs compared against an instruction-level model of the controller.
module tb_cr16_control_fsm;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] pc;
    logic        asel;
    logic        mwe;
    logic [15:0] wen;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        isel;
    logic [15:0] imm;
    logic [3:0]  opc;
    logic        rds;
  } rec_t;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
                         S_LOAD_ADDR = 3'd3, S_LOAD_WB = 3'd4, S_STORE = 3'd5;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic en = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] pc_exp;
  logic [15:0] imem [0:255];

  always #5 clk = ~clk;

  cr16_control_fsm_if bus1 ();
  cr16_control_fsm_if bus2 ();

  cr16_control_fsm #(.PC_RESET(16'h0000)) dut (
    .I_CLK(clk), .I_NRESET(nrst), .I_ENABLE(en), .bus(bus1));

  cr16_control_fsm #(.PC_RESET(16'hFFFF)) dut_wrap (
    .I_CLK(clk), .I_NRESET(nrst), .I_ENABLE(en), .bus(bus2));

  // Synchronous instruction memory addressed by PC (one-cycle read latency).
  always @(posedge clk) begin
    bus1.I_MEM_RDATA <= imem[bus1.O_PC[7:0]];
    bus2.I_MEM_RDATA <= imem[bus2.O_PC[7:0]];
  end

  rec_t o1, o2;
  assign o1 = {bus1.O_STATE, bus1.O_PC, bus1.O_MEM_ADDR_SELECT, bus1.O_MEM_WRITE_ENABLE,
               bus1.O_REG_WRITE_ENABLE, bus1.O_REG_A_SELECT, bus1.O_REG_B_SELECT,
               bus1.O_IMMEDIATE_SELECT, bus1.O_IMMEDIATE, bus1.O_OPCODE,
               bus1.O_REGFILE_DATA_SELECT};
  assign o2 = {bus2.O_STATE, bus2.O_PC, bus2.O_MEM_ADDR_SELECT, bus2.O_MEM_WRITE_ENABLE,
               bus2.O_REG_WRITE_ENABLE, bus2.O_REG_A_SELECT, bus2.O_REG_B_SELECT,
               bus2.O_IMMEDIATE_SELECT, bus2.O_IMMEDIATE, bus2.O_OPCODE,
               bus2.O_REGFILE_DATA_SELECT};

  function automatic logic [3:0] alu_of(input logic [3:0] c);
    case (c)
      4'h1: return 4'd3;
      4'h2: return 4'd4;
      4'h3: return 4'd5;
      4'h5: return 4'd1;
      4'h9: return 4'd2;
      4'hB: return 4'd6;
      4'hD: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic int n_cycles(input logic [15:0] ins);
    return (ins[15:12] == 4'h4 && ins[7:4] == 4'h0) ? 4 : 3;
  endfunction

  // Expected outputs during cycle k of instruction ins fetched from address pc.
  function automatic rec_t expect_rec(input logic [15:0] ins, input logic [15:0] pc, input int k);
    rec_t r;
    logic [3:0] op, ext, rd, rs;
    r   = '0;
    op  = ins[15:12];
    ext = ins[7:4];
    rd  = ins[11:8];
    rs  = ins[3:0];
    r.pc = (k < 2) ? pc : pc + 16'd1;
    if (k == 0) r.st = S_FETCH;
    else if (k == 1) r.st = S_DECODE;
    else if (op == 4'h4 && ext == 4'h0) begin
      if (k == 2) begin r.st = S_LOAD_ADDR; r.asel = 1'b1; r.a = rs; end
      else begin r.st = S_LOAD_WB; r.rds = 1'b1; r.wen = 16'h0001 << rd; end
    end else if (op == 4'h4 && ext == 4'h4) begin
      r.st = S_STORE; r.asel = 1'b1; r.mwe = 1'b1; r.a = rs; r.b = rd;
    end else begin
      r.st = S_EXECUTE;
      if (op == 4'h0 && alu_of(ext) != 4'd0) begin
        r.a = rd; r.b = rs; r.opc = alu_of(ext);
        if (r.opc != 4'd6) r.wen = 16'h0001 << rd;
      end else if (op != 4'h0 && alu_of(op) != 4'd0) begin
        r.a = rd; r.b = rs; r.opc = alu_of(op); r.isel = 1'b1;
        r.imm = (op == 4'h5 || op == 4'h9 || op == 4'hB) ? {{8{ins[7]}}, ins[7:0]}
                                                          : {8'h00, ins[7:0]};
        if (r.opc != 4'd6) r.wen = 16'h0001 << rd;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] pick_code();
    case ($urandom_range(0, 6))
      0: return 4'h1;
      1: return 4'h2;
      2: return 4'h3;
      3: return 4'h5;
      4: return 4'h9;
      5: return 4'hB;
      default: return 4'hD;
    endcase
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [3:0] rd, rs;
    rd = 4'($urandom);
    rs = 4'($urandom);
    case ($urandom_range(0, 4))
      0: return {4'h0, rd, pick_code(), rs};
      1: return {pick_code(), rd, 8'($urandom)};
      2: return {4'h4, rd, 4'h0, rs};
      3: return {4'h4, rd, 4'h4, rs};
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input rec_t got, input rec_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Steps one instruction from its FETCH negedge to the next FETCH negedge.
  task automatic run_instr(input int stall_k, input int abort_k);
    logic [15:0] ins;
    int n;
    ins = imem[pc_exp[7:0]];
    n   = n_cycles(ins);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("pc%04h ins%04h c%0d", pc_exp, ins, k), o1, expect_rec(ins, pc_exp, k));
      if (k == abort_k) begin
        nrst = 1'b0;
        #1;
        chk($sformatf("abort ins%04h", ins), o1, expect_rec(16'h0000, 16'h0000, 0));
        @(negedge clk);
        chk($sformatf("abort hold ins%04h", ins), o1, expect_rec(16'h0000, 16'h0000, 0));
        nrst   = 1'b1;
        pc_exp = 16'h0000;
        return;
      end
      if (k == stall_k) begin
        en = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk($sformatf("stall ins%04h c%0d", ins, k), o1, expect_rec(ins, pc_exp, k));
        end
        en = 1'b1;
      end
      @(negedge clk);
    end
    pc_exp = pc_exp + 16'd1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[0] = 16'hD385;   // MOVI r3,#0x85
    imem[1] = 16'h51FE;   // ADDI r1,#-2
    imem[2] = 16'h0255;   // ADD  r2,r5
    imem[3] = 16'h00B1;   // CMP  r0,r1
    imem[4] = 16'hF000;   // invalid
    imem[5] = 16'h4407;   // LOAD r4,[r7]
    imem[6] = 16'h4246;   // STOR r2,[r6]
    imem[7] = 16'h0A15;   // AND  r10,r5 (stalled in EXECUTE)
    for (int i = 8; i < 48; i++) imem[i] = rand_instr();
    imem[48] = 16'h4C03;  // LOAD r12,[r3], aborted in LOAD_WB
    imem[255] = 16'h0000;

    nrst = 1'b0;
    en   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset", o1, expect_rec(16'h0000, 16'h0000, 0));
    chk("reset wrap", o2, expect_rec(16'h0000, 16'hFFFF, 0));
    nrst   = 1'b1;
    pc_exp = 16'h0000;

    for (int i = 0; i < 48; i++) run_instr((i == 7) ? 2 : -1, -1);
    run_instr(-1, 3);
    for (int i = 0; i < 4; i++) run_instr(-1, -1);

    // PC wrap: second instance restarts at 0xFFFF.
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("wrap reset", o2, expect_rec(imem[255], 16'hFFFF, 0));
    @(negedge clk);
    nrst = 1'b1;
    chk("wrap c0", o2, expect_rec(imem[255], 16'hFFFF, 0));
    @(negedge clk);
    chk("wrap c1", o2, expect_rec(imem[255], 16'hFFFF, 1));
    @(negedge clk);
    chk("wrap c2", o2, expect_rec(imem[255], 16'hFFFF, 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
